// File: rtl/lsu.sv
// rtl/lsu.sv - RV32I load/store unit with misaligned split-access handling.
// One request at a time; unaligned accesses crossing a word take two memory cycles.
module lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  localparam int MASK_SIZE = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  resp_split,
  output logic                  mem_write_en,
  output logic [MASK_SIZE-1:0]  mem_mask,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_we;
  logic [2:0]            r_funct3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_lo;
  logic [DATA_WIDTH-1:0] r_hi;
  logic                  r_err;

  logic                    w_req_illegal;
  logic                    w_accept;
  logic [1:0]              w_off;
  logic [2:0]              w_size;
  logic                    w_split;
  logic [2*MASK_SIZE-1:0]  w_mask_wide;
  logic [DATA_WIDTH-1:0]   w_wdata_sized;
  logic [2*DATA_WIDTH-1:0] w_store_wide;
  logic [2*DATA_WIDTH-1:0] w_load_wide;
  logic [DATA_WIDTH-1:0]   w_load_result;
  logic [ADDR_WIDTH-1:0]   w_word_addr;

  // Loads reject 011/110/111; stores accept only B/H/W.
  assign w_req_illegal = req_we ? (req_funct3[2] | (req_funct3[1:0] == 2'b11))
                                : ((req_funct3[1:0] == 2'b11) | (req_funct3 == 3'b110));

  assign req_ready = arst_n & (r_state == IDLE);
  assign w_accept  = req_valid & (r_state == IDLE);

  assign w_off       = r_addr[1:0];
  assign w_word_addr = {r_addr[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    w_size = 3'd4;
    case (r_funct3[1:0])
      2'b00:   w_size = 3'd1;
      2'b01:   w_size = 3'd2;
      default: w_size = 3'd4;
    endcase
  end

  assign w_split     = ({1'b0, w_off} + w_size) > 3'd4;
  assign w_mask_wide = ((8'd1 << w_size) - 8'd1) << w_off;

  always_comb begin
    w_wdata_sized = r_wdata;
    case (r_funct3[1:0])
      2'b00:   w_wdata_sized = {24'd0, r_wdata[7:0]};
      2'b01:   w_wdata_sized = {16'd0, r_wdata[15:0]};
      default: w_wdata_sized = r_wdata;
    endcase
  end

  assign w_store_wide = {{DATA_WIDTH{1'b0}}, w_wdata_sized} << {w_off, 3'b000};
  assign w_load_wide  = {r_hi, r_lo} >> {w_off, 3'b000};

  always_comb begin
    w_load_result = w_load_wide[DATA_WIDTH-1:0];
    case (r_funct3)
      3'b000:  w_load_result = {{24{w_load_wide[7]}}, w_load_wide[7:0]};
      3'b001:  w_load_result = {{16{w_load_wide[15]}}, w_load_wide[15:0]};
      3'b100:  w_load_result = {24'd0, w_load_wide[7:0]};
      3'b101:  w_load_result = {16'd0, w_load_wide[15:0]};
      default: w_load_result = w_load_wide[DATA_WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state  <= IDLE;
      r_we     <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_lo     <= '0;
      r_hi     <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_err    <= w_req_illegal;
        r_lo     <= '0;
        r_hi     <= '0;
      end
      if (r_state == FIRST && !r_we) r_lo <= mem_rdata;
      if (r_state == SECOND && !r_we) r_hi <= mem_rdata;
    end
  end

  always_comb begin
    w_next       = r_state;
    mem_write_en = 1'b0;
    mem_mask     = '0;
    mem_addr     = '0;
    mem_wdata    = '0;
    resp_valid   = 1'b0;
    resp_rdata   = '0;
    resp_err     = 1'b0;
    resp_split   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next = w_req_illegal ? RESP : FIRST;
      end
      FIRST: begin
        mem_addr     = w_word_addr;
        mem_write_en = r_we;
        mem_mask     = w_mask_wide[MASK_SIZE-1:0];
        mem_wdata    = r_we ? w_store_wide[DATA_WIDTH-1:0] : '0;
        w_next       = w_split ? SECOND : RESP;
      end
      SECOND: begin
        // Word address increment wraps naturally at the top of the address space.
        mem_addr     = w_word_addr + ADDR_WIDTH'(4);
        mem_write_en = r_we;
        mem_mask     = w_mask_wide[2*MASK_SIZE-1:MASK_SIZE];
        mem_wdata    = r_we ? w_store_wide[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
        w_next       = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = r_err;
        resp_split = ~r_err & w_split;
        resp_rdata = (r_we || r_err) ? '0 : w_load_result;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed checks of lsu against a byte-masked word memory.
module tb_lsu;

  logic        clk;
  logic        arst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        resp_split;
  logic        mem_write_en;
  logic [3:0]  mem_mask;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:255];

  int n_pass;
  int n_total;
  int n_fail;

  int          rc;
  logic [31:0] rd;
  logic        re;
  logic        rs;
  int          nw;
  logic [31:0] a_t  [1:4];
  logic [3:0]  m_t  [1:4];
  logic [31:0] wd_t [1:4];

  lsu dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .resp_split   (resp_split),
    .mem_write_en (mem_write_en),
    .mem_mask     (mem_mask),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_write_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_mask[b]) mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request and record four cycles of memory/response activity.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit noise);
    @(negedge clk);
    chk("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    if (noise) begin
      req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h200; req_wdata = 32'hCAFEF00D;
    end else begin
      req_valid = 1'b0;
    end
    rc = 0; rd = '0; re = 1'b0; rs = 1'b0; nw = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      a_t[k] = mem_addr; m_t[k] = mem_mask; wd_t[k] = mem_wdata;
      if (mem_write_en) nw++;
      if (resp_valid) begin
        if (rc == 0) begin
          rc = k; rd = resp_rdata; re = resp_err; rs = resp_split;
        end else begin
          rc = 99;
        end
      end
      if (k == 2) req_valid = 1'b0;
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0; n_fail = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    arst_n = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h100; req_wdata = 32'h55555555;

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_split", 32'(resp_split), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_write_en", 32'(mem_write_en), 32'd0);
    chk("rst_mask", 32'(mem_mask), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    req_valid = 1'b0;
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 32'(req_ready), 32'd1);
    chk("mem100_untouched", mem[64], 32'd0);

    mem[64] = 32'hDEADBEEF;
    do_req(1'b0, 3'b010, 32'h100, 32'd0, 1'b0);
    chk("lw_latency", 32'(rc), 32'd2);
    chk("lw_addr", a_t[1], 32'h100);
    chk("lw_mask", 32'(m_t[1]), 32'hF);
    chk("lw_writes", 32'(nw), 32'd0);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_split", 32'(rs), 32'd0);
    chk("lw_err", 32'(re), 32'd0);
    chk("lw_resp_addr", a_t[2], 32'd0);
    chk("lw_resp_mask", 32'(m_t[2]), 32'd0);

    mem[64] = 32'h80123456;
    do_req(1'b0, 3'b000, 32'h103, 32'd0, 1'b0);
    chk("lb_rdata", rd, 32'hFFFFFF80);
    chk("lb_mask", 32'(m_t[1]), 32'h8);
    do_req(1'b0, 3'b100, 32'h103, 32'd0, 1'b0);
    chk("lbu_rdata", rd, 32'h00000080);

    mem[64] = 32'hAAAAAAAA;
    mem[65] = 32'hBBBBBBBB;
    do_req(1'b1, 3'b010, 32'h102, 32'h11223344, 1'b0);
    chk("sw_latency", 32'(rc), 32'd3);
    chk("sw_split", 32'(rs), 32'd1);
    chk("sw_rdata", rd, 32'd0);
    chk("sw_addr1", a_t[1], 32'h100);
    chk("sw_mask1", 32'(m_t[1]), 32'hC);
    chk("sw_data1", wd_t[1] & 32'hFFFF0000, 32'h33440000);
    chk("sw_addr2", a_t[2], 32'h104);
    chk("sw_mask2", 32'(m_t[2]), 32'h3);
    chk("sw_data2", wd_t[2] & 32'h0000FFFF, 32'h00001122);
    chk("sw_writes", 32'(nw), 32'd2);
    chk("sw_resp_mask", 32'(m_t[3]), 32'd0);

    do_req(1'b0, 3'b010, 32'h100, 32'd0, 1'b0);
    chk("sw_mem_lo", rd, 32'h3344AAAA);
    do_req(1'b0, 3'b010, 32'h104, 32'd0, 1'b1);
    chk("sw_mem_hi", rd, 32'hBBBB1122);
    chk("busy_ignored_writes", 32'(nw), 32'd0);
    chk("busy_ignored_latency", 32'(rc), 32'd2);

    do_req(1'b0, 3'b010, 32'h101, 32'd0, 1'b0);
    chk("lw_mis_latency", 32'(rc), 32'd3);
    chk("lw_mis_split", 32'(rs), 32'd1);
    chk("lw_mis_mask1", 32'(m_t[1]), 32'hE);
    chk("lw_mis_mask2", 32'(m_t[2]), 32'h1);
    chk("lw_mis_rdata", rd, 32'h223344AA);

    do_req(1'b0, 3'b001, 32'h102, 32'd0, 1'b0);
    chk("lh_edge_latency", 32'(rc), 32'd2);
    chk("lh_edge_split", 32'(rs), 32'd0);
    chk("lh_edge_rdata", rd, 32'h00003344);

    do_req(1'b1, 3'b000, 32'h107, 32'hDEAD55F0, 1'b0);
    chk("sb_latency", 32'(rc), 32'd2);
    chk("sb_mask", 32'(m_t[1]), 32'h8);
    chk("sb_data", wd_t[1] & 32'hFF000000, 32'hF0000000);
    do_req(1'b0, 3'b010, 32'h104, 32'd0, 1'b0);
    chk("sb_mem", rd, 32'hF0BB1122);

    mem[255] = 32'hA5665544;
    mem[0]   = 32'h1234569C;
    do_req(1'b0, 3'b001, 32'hFFFFFFFF, 32'd0, 1'b0);
    chk("lh_wrap_addr1", a_t[1], 32'hFFFFFFFC);
    chk("lh_wrap_mask1", 32'(m_t[1]), 32'h8);
    chk("lh_wrap_addr2", a_t[2], 32'h00000000);
    chk("lh_wrap_mask2", 32'(m_t[2]), 32'h1);
    chk("lh_wrap_split", 32'(rs), 32'd1);
    chk("lh_wrap_latency", 32'(rc), 32'd3);
    chk("lh_wrap_rdata", rd, 32'hFFFF9CA5);
    do_req(1'b0, 3'b101, 32'hFFFFFFFF, 32'd0, 1'b0);
    chk("lhu_wrap_rdata", rd, 32'h00009CA5);

    do_req(1'b1, 3'b011, 32'h100, 32'h12345678, 1'b0);
    chk("st_err_latency", 32'(rc), 32'd1);
    chk("st_err_flag", 32'(re), 32'd1);
    chk("st_err_rdata", rd, 32'd0);
    chk("st_err_split", 32'(rs), 32'd0);
    chk("st_err_writes", 32'(nw), 32'd0);
    chk("st_err_mask", 32'(m_t[1]), 32'd0);
    do_req(1'b0, 3'b110, 32'h100, 32'd0, 1'b0);
    chk("ld110_latency", 32'(rc), 32'd1);
    chk("ld110_err", 32'(re), 32'd1);
    do_req(1'b0, 3'b111, 32'h100, 32'd0, 1'b0);
    chk("ld111_err", 32'(re), 32'd1);
    chk("mem200_untouched", mem[128], 32'd0);

    mem[64] = 32'h11111111;
    mem[65] = 32'h22222222;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
    req_addr = 32'h103; req_wdata = 32'h00007788;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_sh_first_we", 32'(mem_write_en), 32'd1);
    chk("rst_sh_first_mask", 32'(mem_mask), 32'h8);
    chk("rst_sh_first_data", mem_wdata & 32'hFF000000, 32'h88000000);
    #1;
    arst_n = 1'b0;
    #1;
    chk("rst_async_we", 32'(mem_write_en), 32'd0);
    chk("rst_async_mask", 32'(mem_mask), 32'd0);
    chk("rst_async_addr", mem_addr, 32'd0);
    chk("rst_async_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("rst_hold_we", 32'(mem_write_en), 32'd0);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_release_ready", 32'(req_ready), 32'd1);
    nw = 0;
    repeat (3) begin
      @(negedge clk);
      if (mem_write_en) nw++;
    end
    chk("rst_no_second_write", 32'(nw), 32'd0);
    chk("rst_mem104", mem[65], 32'h22222222);
    do_req(1'b0, 3'b010, 32'h100, 32'd0, 1'b0);
    chk("post_rst_lw_latency", 32'(rc), 32'd2);
    chk("post_rst_lw_rdata", rd, 32'h11111111);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
